// File: rtl/muxn_stream.sv
// muxn_stream: registered N-input stream multiplexer with valid/ready handshaking.
// Picks one of NUM_INPUTS producer channels, either by an explicit select or by
// round-robin arbitration, and forwards its word through a single output register.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   s        channel select (explicit mode only)
//   d        packed channel data, channel i at [i*(WIREWIDTH+1) +: WIREWIDTH+1]
//   d_valid  per-channel valid
//   d_ready  per-channel ready (combinational, at most one bit set)
//   o        registered output data
//   o_valid  output valid
//   o_ready  consumer ready
//   o_src    channel index that produced the current o
module muxn_stream #(
  parameter int unsigned WIREWIDTH   = 1,
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned SELW        = 2,
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [SELW-1:0]                     s,
  input  logic [NUM_INPUTS*(WIREWIDTH+1)-1:0] d,
  input  logic [NUM_INPUTS-1:0]               d_valid,
  output logic [NUM_INPUTS-1:0]               d_ready,
  output logic [WIREWIDTH:0]                  o,
  output logic                                o_valid,
  input  logic                                o_ready,
  output logic [SELW-1:0]                     o_src
);

  localparam int unsigned DW = WIREWIDTH + 1;

  logic [DW-1:0]         data_q;
  logic                  valid_q;
  logic [SELW-1:0]       src_q;
  logic [SELW-1:0]       ptr_q;
  logic [SELW-1:0]       ptr_d;

  logic [SELW-1:0]       gnt;
  logic                  gnt_ok;
  logic                  free;
  logic                  load;
  logic [DW-1:0]         data_sel;
  logic [NUM_INPUTS-1:0] dv_rot;
  int unsigned           rr_idx;

  assign free = !valid_q || o_ready;
  // Gating with rst_n keeps every d_ready low while reset is held; the first
  // edge after release may already load.
  assign load = rst_n && gnt_ok && free;

  // Grant selection
  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    rr_idx = 0;
    dv_rot = NUM_INPUTS'({d_valid, d_valid} >> ptr_q);
    if (ROUND_ROBIN != 0) begin
      // dv_rot[k] is the valid of channel (ptr + k) mod NUM_INPUTS; first hit wins.
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (!gnt_ok && dv_rot[k]) begin
          gnt_ok = 1'b1;
          rr_idx = 32'(ptr_q) + 32'(k);
          if (rr_idx >= NUM_INPUTS) begin
            rr_idx = rr_idx - NUM_INPUTS;
          end
          gnt = SELW'(rr_idx);
        end
      end
    end else begin
      gnt = s;
      // An out-of-range select matches no channel and so never grants.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (s == SELW'(i)) begin
          gnt_ok = d_valid[i];
        end
      end
    end
  end

  // Data mux and per-channel ready
  always_comb begin
    data_sel = '0;
    d_ready  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (gnt == SELW'(i)) begin
        data_sel   = d[i*DW +: DW];
        d_ready[i] = load;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load && (ROUND_ROBIN != 0)) begin
      ptr_d = (gnt == SELW'(NUM_INPUTS - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        data_q  <= data_sel;
        src_q   <= gnt;
        valid_q <= 1'b1;
      end else if (valid_q && o_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o       = data_q;
  assign o_valid = valid_q;
  assign o_src   = src_q;

endmodule
